// File: rtl/rename_free_list_pkg.sv
// Shared types and sizing for the physical-register free list.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rename_free_list_pkg;

  localparam int NUM_PHYS        = 64;
  localparam int NUM_ARCH        = 32;
  localparam int MAX_IDS         = 32;
  localparam int FREE_LIST_DEPTH = NUM_PHYS - NUM_ARCH;

  localparam int PW = $clog2(NUM_PHYS);
  localparam int IW = $clog2(MAX_IDS);
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int DW = $clog2(FREE_LIST_DEPTH) + 1;
  localparam int AW = DW - 1;

  typedef logic [PW-1:0] phys_addr_t;
  typedef logic [IW-1:0] id_t;
  typedef logic [DW-1:0] fl_ptr_t;
  typedef logic [AW-1:0] fl_addr_t;

  typedef enum logic {
    FL_INIT = 1'b0,
    FL_RUN  = 1'b1
  } fl_state_t;

  // RAM index of a wrapped pointer: drop the wrap bit.
  function automatic fl_addr_t fl_index(input fl_ptr_t ptr);
    return ptr[AW-1:0];
  endfunction

  // Full when the RAM indices match but the wrap bits differ.
  function automatic logic fl_is_full(input fl_ptr_t tail, input fl_ptr_t head);
    return (fl_index(tail) == fl_index(head)) && (tail[DW-1] != head[DW-1]);
  endfunction

endpackage

// File: rtl/rename_free_list_ram.sv
// Free-list storage: DEPTH x PW, one synchronous write port, one async read port.
// Latency: write visible on rdata the cycle after we; read is combinational.
// Backpressure: none, accepts a write every cycle.
module rename_free_list_ram
  import rename_free_list_pkg::*;
(
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [PW-1:0] rdata
);

  phys_addr_t mem [FREE_LIST_DEPTH];

  // Single write port; no reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rename_free_list.sv
// Physical-register free list: hands free regs to decode, recycles displaced regs at retire.
// Latency: retired reg visible on alloc_phys next cycle (same cycle when RENAME_FREE_LIST_BYPASS_EN is defined).
// Backpressure: alloc_valid low when empty or initialising; decode must not consume then.
module rename_free_list
  import rename_free_list_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          fetch_flush,
  input  logic          decode_alloc,
  input  logic [IW-1:0] decode_id,
  input  logic [PW-1:0] decode_prev_phys,
  output logic [PW-1:0] alloc_phys,
  output logic          alloc_valid,
  input  logic          issue_with_rd,
  input  logic          retire_valid,
  input  logic [IW-1:0] retire_id,
  output logic [DW-1:0] free_count,
  output logic          init_done
);

  fl_state_t  state;
  fl_addr_t   init_cnt;
  fl_ptr_t    spec_head;
  fl_ptr_t    issued_head;
  fl_ptr_t    tail;
  fl_ptr_t    issued_head_next;

  phys_addr_t prev_table [MAX_IDS];
  phys_addr_t retire_phys;
  phys_addr_t ram_rdata;

  logic       running;
  logic       list_empty;
  logic       list_full;
  logic       pop;
  logic       push;

  logic       ram_we;
  fl_addr_t   ram_waddr;
  phys_addr_t ram_wdata;

  localparam fl_addr_t INIT_LAST = fl_addr_t'(FREE_LIST_DEPTH - 1);

  assign running    = (state == FL_RUN);
  assign list_empty = (tail == spec_head);
  assign list_full  = fl_is_full(tail, spec_head);

  // Register displaced by the retiring instruction, recorded when it decoded.
  assign retire_phys = prev_table[retire_id];

  // Offer the head entry; a retire into an empty list may be forwarded when bypass is built in.
  always_comb begin
    alloc_valid = running & ~list_empty;
    alloc_phys  = running ? ram_rdata : '0;
`ifdef RENAME_FREE_LIST_BYPASS_EN
    if (running && list_empty && retire_valid) begin
      alloc_valid = 1'b1;
      alloc_phys  = retire_phys;
    end
`endif
  end

  // A flush squashes the decode in the same cycle; retire pushes are never squashed.
  assign pop  = running & decode_alloc & ~fetch_flush & alloc_valid;
  assign push = running & retire_valid;

  // Rollback target must include an issue happening in the flush cycle itself.
  assign issued_head_next = issued_head + fl_ptr_t'(running & issue_with_rd);

  assign free_count = running ? fl_ptr_t'(tail - spec_head) : '0;

  // During INIT the RAM is filled with the non-architectural registers; afterwards only retire writes.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = fl_index(tail);
    ram_wdata = retire_phys;
    if (!rst) begin
      if (running) begin
        ram_we = push;
      end else begin
        ram_we    = 1'b1;
        ram_waddr = init_cnt;
        ram_wdata = phys_addr_t'(NUM_ARCH) + phys_addr_t'(init_cnt);
      end
    end
  end

  rename_free_list_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (fl_index(spec_head)),
    .rdata (ram_rdata)
  );

  // Init/run state machine owning all three pointers and the init_done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FL_INIT;
      init_cnt    <= '0;
      spec_head   <= '0;
      issued_head <= '0;
      tail        <= '0;
      init_done   <= 1'b0;
    end else begin
      case (state)
        FL_INIT: begin
          init_cnt <= init_cnt + fl_addr_t'(1);
          if (init_cnt == INIT_LAST) begin
            // Every non-architectural register is now free: list starts full.
            tail      <= fl_ptr_t'(FREE_LIST_DEPTH);
            init_done <= 1'b1;
            state     <= FL_RUN;
          end
        end
        FL_RUN: begin
          issued_head <= issued_head_next;
          if (fetch_flush) begin
            spec_head <= issued_head_next;
          end else if (pop) begin
            spec_head <= spec_head + fl_ptr_t'(1);
          end
          if (push) begin
            tail <= tail + fl_ptr_t'(1);
          end
        end
        default: begin
          state <= FL_INIT;
        end
      endcase
    end
  end

  // Remember which register each decoding instruction displaces, for recycling at retire.
  always_ff @(posedge clk) begin
    if (pop) begin
      prev_table[decode_id] <= decode_prev_phys;
    end
  end

  // Protocol checks on the decode/issue/retire interfaces.
  always_ff @(posedge clk) begin
    if (!rst && running) begin
      a_pop_when_valid : assert (!(decode_alloc && !alloc_valid))
        else $error("decode_alloc while no free register is offered");
      a_issue_behind_spec : assert (!(issue_with_rd && (issued_head == spec_head)))
        else $error("issue_with_rd with no outstanding allocation");
      a_push_not_full : assert (!(retire_valid && list_full))
        else $error("retire push into a full free list");
    end
  end

endmodule

// File: doc/rename_free_list.md
Name: rename_free_list

Overview:
- Physical-register free list for the renamer. Sits between the retire packet from ID management and the decode stage.
- At decode, supplies a free physical register to each instruction that writes rd. It also records, per instruction ID, the physical register that instruction displaces.
- At retire, pushes the displaced register back onto the list.
- On a fetch flush, rolls the speculative head back to the oldest un-issued allocation.

Parameters:
- NUM_PHYS, 64, total physical registers; phys_addr width PW = $clog2(NUM_PHYS).
- NUM_ARCH, 32, architectural registers; phys 0..NUM_ARCH-1 are the initial identity mapping.
- MAX_IDS, 32, instruction ID space; ID width IW = $clog2(MAX_IDS).
- DEPTH, NUM_PHYS-NUM_ARCH (32), free-list capacity; pointer width DW = $clog2(DEPTH)+1 (extra wrap bit).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- fetch_flush  in  1  gc fetch flush; discards decoded-but-unissued allocations.
- decode_alloc  in  1  decode advancing with an rd that is not x0; consumes alloc_phys.
- decode_id  in  IW  ID of the decoding instruction.
- decode_prev_phys  in  PW  current rename-table mapping of decode rd, i.e. the register being displaced.
- alloc_phys  out  PW  free register offered to decode.
- alloc_valid  out  1  alloc_phys is usable.
- issue_with_rd  in  1  an instruction holding an allocation issued this cycle.
- retire_valid  in  1  retire packet valid (an rd-writing instruction retired).
- retire_id  in  IW  retire packet phys_id field, i.e. the ID of the retiring instruction.
- free_count  out  DW  entries currently free (tail - spec_head).
- init_done  out  1  initialisation complete.

Behaviour:
- Storage:
  - free_ram[DEPTH] of PW bits.
  - prev_table[MAX_IDS] of PW bits, written at decode_id on decode_alloc.
  - Pointers spec_head, issued_head and tail, each DW bits. The low bits index the RAM; the MSB is the wrap bit.
- FSM states INIT and RUN.
  - rst -> INIT with init_cnt=0 and all pointers 0.
  - In INIT: write free_ram[init_cnt] <= NUM_ARCH+init_cnt each cycle. After DEPTH cycles, set tail=DEPTH (full) and go to RUN.
  - Reset asserted mid-INIT or mid-RUN restarts INIT.
- Outputs during INIT and at reset: init_done=0, alloc_valid=0, free_count=0, alloc_phys=0.
- alloc_phys = free_ram[spec_head] (combinational read).
- alloc_valid = RUN & (tail != spec_head).
- Pop:
  - decode_alloc & ~fetch_flush: spec_head+1 and prev_table write.
  - decode_alloc while ~alloc_valid is an error (assertion).
- Issue: issue_with_rd increments issued_head.
  - Issue is in-order, so issued_head never passes spec_head (asserted).
- Push: retire_valid writes free_ram[tail] <= prev_table[retire_id] and increments tail, one push per cycle max.
  - Pushing while full (tail-spec_head==DEPTH) is an error (assertion).
- Flush: fetch_flush sets spec_head <= issued_head_next, where issued_head_next includes an issue in the same cycle.
  - A retire push in the flush cycle still completes.
- Latency: a pushed register is visible on alloc_phys the cycle after the push. There is no same-cycle bypass unless the optional feature is compiled in.
- Simultaneous push and pop when non-empty: both take effect.
- Simultaneous push and pop when empty: the pop is illegal (alloc_valid=0) without the feature.
- Pointer arithmetic is modulo 2·DEPTH.
  - Empty when the pointers are equal.
  - Full when the low bits are equal and the MSBs differ.

Optional Feature:
- Macro: RENAME_FREE_LIST_BYPASS_EN.
- With the macro: when the list is empty and retire_valid is high, alloc_valid=1 and alloc_phys=prev_table[retire_id] combinationally. A decode_alloc in that cycle consumes the pushed register; tail and spec_head both increment.
- Without the macro: alloc_valid depends only on registered pointers, and there is no retire-to-decode combinational path.

Decomposition:
- Shared package (cva5_types / cva5_config): phys_addr_t, id_t, the free-list pointer type and the FREE_LIST_DEPTH constant.
- One natural sub-module: free_list_ram, a DEPTH x PW single-write, single-async-read LUTRAM.

Test Plan:
- Init: release rst -> init_done rises after 32 cycles; alloc_phys=32 and free_count=32.
- Drain: 32 back-to-back decode_alloc with no issue or retire -> alloc_phys steps 32..63, then alloc_valid=0 and free_count=0.
- Retire recycle: decode id 5 with prev_phys=7, issue, then retire_valid with retire_id=5 -> the next cycle tail pushes 7; after the list is drained, 7 is offered in FIFO order.
- Flush rollback: allocate 3 registers (32,33,34), issue 1, then fetch_flush -> spec_head returns to 33 and alloc_phys=33 the next cycle; free_count=31.
- Flush with concurrent issue and retire: in one cycle, fetch_flush + issue_with_rd + retire_valid -> spec_head=issued_head+1 and tail increments by 1.
- Bypass (macro on): list empty, retire_valid and decode_alloc in the same cycle with prev=9 -> alloc_phys=9 and alloc_valid=1 that cycle; free_count stays 0. With the macro off, alloc_valid=0.
